// File: rtl/trng_byte_collector.sv
// Collects raw SR-latch entropy bits, optionally von Neumann debiases them, packs
// WIDTH-bit words onto a valid/ready port and runs a repetition-count health test.
module trng_byte_collector #(
  parameter int WIDTH     = 8,
  parameter int DEBIAS    = 1,
  parameter int REP_LIMIT = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enabled,
  input  logic             raw_bit,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             health_fail,
  output logic [7:0]       drop_cnt
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int RW = $clog2(REP_LIMIT + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [RW-1:0] REP_MAX  = RW'(REP_LIMIT);

  typedef enum logic {FIRST, SECOND} pair_e;

  pair_e            state_q, state_d;
  logic             p0_q;
  logic             prev_q;
  logic [WIDTH-1:0] shreg_q;
  logic [CW-1:0]    bcnt_q;
  logic [RW-1:0]    rep_q, rep_d;
  logic             acc_vld, acc_bit;
  logic [WIDTH-1:0] word;
  logic             slot_free;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [RW-1:0] sat_inc_rep(input logic [RW-1:0] v);
    return (v >= REP_MAX) ? REP_MAX : v + RW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state_q <= FIRST;
    else       state_q <= state_d;
  end

  // Pair FSM: the second sample of a discordant pair yields the first sample's value.
  always_comb begin
    state_d = state_q;
    acc_vld = 1'b0;
    acc_bit = raw_bit;
    if (!enabled) begin
      state_d = FIRST;
    end else if (DEBIAS == 0) begin
      acc_vld = 1'b1;
      state_d = FIRST;
    end else begin
      case (state_q)
        FIRST:  state_d = SECOND;
        SECOND: begin
          state_d = FIRST;
          acc_vld = p0_q ^ raw_bit;
          acc_bit = p0_q;
        end
        default: state_d = FIRST;
      endcase
    end
  end

  always_comb begin
    if (rep_q == '0)            rep_d = RW'(1);
    else if (raw_bit == prev_q) rep_d = sat_inc_rep(rep_q);
    else                        rep_d = RW'(1);
  end

  assign word      = {shreg_q[WIDTH-2:0], acc_bit};
  assign slot_free = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data    <= '0;
      out_valid   <= 1'b0;
      health_fail <= 1'b0;
      drop_cnt    <= '0;
      shreg_q     <= '0;
      bcnt_q      <= '0;
      rep_q       <= '0;
      prev_q      <= 1'b0;
      p0_q        <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (enabled) begin
        if (state_q == FIRST) p0_q <= raw_bit;
        prev_q <= raw_bit;
        rep_q  <= rep_d;
        if (rep_d == REP_MAX) health_fail <= 1'b1;
        if (acc_vld) begin
          shreg_q <= word;
          if (bcnt_q == LAST_BIT) begin
            bcnt_q <= '0;
            // A word completing while the slot is busy (or after a health failure) is lost.
            if (!health_fail && slot_free) begin
              out_data  <= word;
              out_valid <= 1'b1;
            end else if (!health_fail) begin
              drop_cnt <= sat_inc8(drop_cnt);
            end
          end else begin
            bcnt_q <= bcnt_q + CW'(1);
          end
        end
      end else begin
        shreg_q <= '0;
        bcnt_q  <= '0;
        rep_q   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_trng_byte_collector.sv
// Randomized and directed bench for trng_byte_collector with a queue-based reference model.
module tb_trng_byte_collector;

  logic       clk = 1'b0;
  logic       reset, enabled, raw_bit, out_ready;
  logic [7:0] out_data;
  logic       out_valid, health_fail;
  logic [7:0] drop_cnt;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  int   pend;          // -1 = no half pair held
  bit   q[$];          // accepted bits of the word under construction
  int   m_data, m_drop, run_len, last_raw;
  bit   m_valid, m_fail;

  always #5 clk = ~clk;

  trng_byte_collector #(.WIDTH(8), .DEBIAS(1), .REP_LIMIT(32)) dut (
    .clk(clk), .reset(reset), .enabled(enabled), .raw_bit(raw_bit),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .health_fail(health_fail), .drop_cnt(drop_cnt)
  );

  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit rst, input bit en, input bit raw, input bit rdy);
    bit nv, fail_set;
    int w;
    if (rst) begin
      pend = -1; q.delete(); m_data = 0; m_drop = 0; run_len = 0; last_raw = 0;
      m_valid = 0; m_fail = 0;
      return;
    end
    nv = m_valid && !rdy;
    fail_set = 0;
    if (en) begin
      if (run_len == 0 || int'(raw) != last_raw) run_len = 1;
      else if (run_len < 32) run_len++;
      last_raw = raw;
      fail_set = (run_len == 32);
      if (pend < 0) pend = raw;
      else begin
        if (pend != int'(raw)) q.push_back(bit'(pend));
        pend = -1;
      end
      if (q.size() == 8) begin
        w = 0;
        foreach (q[i]) w += int'(q[i]) << (7 - i);
        q.delete();
        if (!m_fail) begin
          if (!m_valid || rdy) begin m_data = w; nv = 1; end
          else if (m_drop < 255) m_drop++;
        end
      end
      if (fail_set) m_fail = 1;
    end else begin
      pend = -1; q.delete(); run_len = 0;
    end
    m_valid = nv;
  endtask

  task automatic cyc(input bit rst, input bit en, input bit raw, input bit rdy);
    reset = rst; enabled = en; raw_bit = raw; out_ready = rdy;
    @(posedge clk);
    model_step(rst, en, raw, rdy);
    #1;
    check("out_valid", int'(out_valid), int'(m_valid));
    check("out_data", int'(out_data), m_data);
    check("health_fail", int'(health_fail), int'(m_fail));
    check("drop_cnt", int'(drop_cnt), m_drop);
  endtask

  // Feeds one byte as discordant pairs, MSB first: pair (b, !b) accepts b.
  task automatic pairs(input logic [7:0] w, input bit rdy);
    for (int i = 7; i >= 0; i--) begin
      cyc(0, 1, w[i], rdy);
      cyc(0, 1, !w[i], rdy);
    end
  endtask

  initial begin
    logic [7:0] b2;
    logic [31:0] r;
    bit sticky, rdy_r;
    b2 = 8'hB2;
    reset = 1; enabled = 0; raw_bit = 0; out_ready = 0;
    pend = -1; m_data = 0; m_drop = 0; run_len = 0; last_raw = 0; m_valid = 0; m_fail = 0;

    cyc(1, 0, 0, 0);
    check("reset_valid", int'(out_valid), 0);
    check("reset_fail", int'(health_fail), 0);

    // 1: basic debiased word
    pairs(b2, 1);
    check("t1_valid", int'(out_valid), 1);
    check("t1_data", int'(out_data), 'hB2);
    cyc(0, 0, 0, 1);
    check("t1_clear", int'(out_valid), 0);

    // 2: concordant pairs interleaved, accepted nothing
    for (int i = 7; i >= 0; i--) begin
      cyc(0, 1, b2[i], 1); cyc(0, 1, !b2[i], 1);
      if (i % 2 == 1) begin cyc(0, 1, i[1], 1); cyc(0, 1, i[1], 1); end
    end
    check("t2_data", int'(out_data), 'hB2);
    check("t2_valid", int'(out_valid), 1);
    cyc(0, 0, 0, 1);

    // 3: backpressure, second word dropped
    pairs(b2, 0);
    pairs(8'h5C, 0);
    check("t3_held", int'(out_data), 'hB2);
    check("t3_drop", int'(drop_cnt), 1);
    cyc(0, 0, 0, 1);
    check("t3_drain", int'(out_valid), 0);

    // 4: repetition failure
    cyc(1, 0, 0, 1);
    for (int i = 0; i < 32; i++) begin
      if (i == 31) check("t4_before", int'(health_fail), 0);
      cyc(0, 1, 1, 1);
    end
    check("t4_fail", int'(health_fail), 1);
    pairs(8'hA5, 1);
    check("t4_nodata", int'(out_valid), 0);
    check("t4_sticky", int'(health_fail), 1);
    cyc(1, 0, 0, 1);
    check("t4_reset", int'(health_fail), 0);

    // 5: reset with a pending word and a partial word
    pairs(8'h3C, 0);
    for (int i = 0; i < 5; i++) begin cyc(0, 1, 1, 0); cyc(0, 1, 0, 0); end
    cyc(1, 1, 1, 0);
    check("t5_valid", int'(out_valid), 0);
    check("t5_data", int'(out_data), 0);
    pairs(8'h69, 1);
    check("t5_word", int'(out_data), 'h69);

    // 6: enable drop mid-pair discards half pair and partial word
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin cyc(0, 1, 1, 1); cyc(0, 1, 0, 1); end
    cyc(0, 1, 0, 1);
    cyc(0, 0, 1, 1);
    pairs(8'hC3, 1);
    check("t6_word", int'(out_data), 'hC3);
    check("t6_valid", int'(out_valid), 1);

    // drop counter saturation
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 258; i++) pairs(8'($urandom), 0);
    check("sat_drop", int'(drop_cnt), 255);
    cyc(1, 0, 0, 0);

    // randomized stream with sticky-run phases to exercise the health test
    sticky = 0; rdy_r = 1;
    for (int i = 0; i < 6000; i++) begin
      if (i % 250 == 0) sticky = ($urandom_range(0, 2) == 0);
      r = $urandom;
      if (sticky) raw_bit = (r[3:0] == 0) ? !raw_bit : raw_bit;
      else        raw_bit = r[0];
      rdy_r = (r[7:6] != 0);
      cyc((r[31:23] == 0), (r[15:11] != 0), raw_bit, rdy_r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
